// File: rtl/cyclic_decoder_7_4_if.sv
// Signal bundle for the serial (7,4) cyclic decoder: bit stream in, decoded result and status out.
interface cyclic_decoder_7_4_if;
    // Flow control is valid-only: a bit is taken on every rising edge where in_valid=1
    // and sync_clr=0; the decoder never back-pressures. out_valid is a single-cycle strobe.
    logic       in_valid;
    logic       in_bit;
    logic       sync_clr;
    logic [3:0] data_out;
    logic       out_valid;
    logic [2:0] syndrome;
    logic       corrected;
    logic [2:0] err_pos;
    logic [2:0] bit_cnt;
    logic [7:0] err_count;

    modport master (
        output in_valid, in_bit, sync_clr,
        input  data_out, out_valid, syndrome, corrected, err_pos, bit_cnt, err_count
    );

    modport slave (
        input  in_valid, in_bit, sync_clr,
        output data_out, out_valid, syndrome, corrected, err_pos, bit_cnt, err_count
    );
endinterface

// File: rtl/cyclic_decoder_7_4.sv
// Serial single-error-correcting decoder for the (7,4) cyclic code g(x) = 1 + x + x^3.
// Syndrome is built by an LFSR divider; one bit is flipped by syndrome lookup.
module cyclic_decoder_7_4 (
    input  logic                  clk,
    input  logic                  rst,
    cyclic_decoder_7_4_if.slave   bus
);

    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic [2:0] lfsr_q,      lfsr_d;
    logic [6:0] r_q,         r_d;
    logic [3:0] data_q,      data_d;
    logic       out_valid_q, out_valid_d;
    logic [2:0] syn_q,       syn_d;
    logic       corr_q,      corr_d;
    logic [2:0] pos_q,       pos_d;
    logic [7:0] err_cnt_q,   err_cnt_d;

    logic       accept;
    logic       last_bit;
    logic       fb;
    logic [2:0] lfsr_step;
    logic [6:0] r_step;
    logic [2:0] pos_lookup;
    logic [6:0] flip_mask;
    logic [6:0] r_fixed;

    // Syndrome of the complete word is the LFSR state after the 7th bit is folded in.
    always_comb begin
        accept    = bus.in_valid & ~bus.sync_clr;
        last_bit  = accept && (bit_cnt_q == 3'd6);
        fb        = lfsr_q[2];
        lfsr_step = {lfsr_q[1], lfsr_q[0] ^ fb, bus.in_bit ^ fb};
        r_step    = {r_q[5:0], bus.in_bit};
    end

    // Syndrome equals x^i mod g(x) for a single error at position i.
    always_comb begin
        pos_lookup = 3'd0;
        flip_mask  = 7'b0000000;
        case (lfsr_step)
            3'b001:  begin pos_lookup = 3'd0; flip_mask = 7'b0000001; end
            3'b010:  begin pos_lookup = 3'd1; flip_mask = 7'b0000010; end
            3'b100:  begin pos_lookup = 3'd2; flip_mask = 7'b0000100; end
            3'b011:  begin pos_lookup = 3'd3; flip_mask = 7'b0001000; end
            3'b110:  begin pos_lookup = 3'd4; flip_mask = 7'b0010000; end
            3'b111:  begin pos_lookup = 3'd5; flip_mask = 7'b0100000; end
            3'b101:  begin pos_lookup = 3'd6; flip_mask = 7'b1000000; end
            default: begin pos_lookup = 3'd0; flip_mask = 7'b0000000; end
        endcase
        r_fixed = r_step ^ flip_mask;
    end

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        lfsr_d      = lfsr_q;
        r_d         = r_q;
        data_d      = data_q;
        out_valid_d = 1'b0;
        syn_d       = syn_q;
        corr_d      = corr_q;
        pos_d       = pos_q;
        err_cnt_d   = err_cnt_q;

        if (bus.sync_clr) begin
            bit_cnt_d = 3'd0;
            lfsr_d    = 3'd0;
            r_d       = 7'd0;
        end else if (accept) begin
            if (last_bit) begin
                // Clearing here lets a bit on the strobe cycle start the next word from 000.
                bit_cnt_d   = 3'd0;
                lfsr_d      = 3'd0;
                r_d         = 7'd0;
                out_valid_d = 1'b1;
                data_d      = r_fixed[6:3];
                syn_d       = lfsr_step;
                corr_d      = (lfsr_step != 3'd0);
                pos_d       = pos_lookup;
                if ((lfsr_step != 3'd0) && (err_cnt_q != 8'hFF)) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                lfsr_d    = lfsr_step;
                r_d       = r_step;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q   <= 3'd0;
            lfsr_q      <= 3'd0;
            r_q         <= 7'd0;
            data_q      <= 4'd0;
            out_valid_q <= 1'b0;
            syn_q       <= 3'd0;
            corr_q      <= 1'b0;
            pos_q       <= 3'd0;
            err_cnt_q   <= 8'd0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            lfsr_q      <= lfsr_d;
            r_q         <= r_d;
            data_q      <= data_d;
            out_valid_q <= out_valid_d;
            syn_q       <= syn_d;
            corr_q      <= corr_d;
            pos_q       <= pos_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.syndrome  = syn_q;
    assign bus.corrected = corr_q;
    assign bus.err_pos   = pos_q;
    assign bus.bit_cnt   = bit_cnt_q;
    assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_cyclic_decoder_7_4.sv
// Bench for cyclic_decoder_7_4: directed sequence plus random codewords against a polynomial-division model.
module tb_cyclic_decoder_7_4;

    localparam int W = 19;  // {data[3:0], syndrome[2:0], corrected, err_pos[2:0], err_count[7:0]}

    logic clk;
    logic rst;
    cyclic_decoder_7_4_if bus ();

    cyclic_decoder_7_4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q [$];
    int           pulse_cyc [$];
    int           n_checks = 0;
    int           n_pass   = 0;

    logic [6:0]   mdl_r    = 7'd0;
    int           mdl_n    = 0;
    int           mdl_errs = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    // Remainder of a 7-bit polynomial by g(x) = x^3 + x + 1 via long division.
    function automatic logic [2:0] poly_mod(input logic [6:0] v);
        logic [6:0] x;
        logic [6:0] g;
        x = v;
        g = 7'b0001011;
        for (int d = 6; d >= 3; d--) begin
            if (x[d]) x = x ^ (g << (d - 3));
        end
        return x[2:0];
    endfunction

    function automatic logic [6:0] encode(input logic [3:0] m);
        return {m, poly_mod({m, 3'b000})};
    endfunction

    function automatic logic [W-1:0] decode_ref(input logic [6:0] r, input int errs);
        logic [2:0] s;
        logic [2:0] pos;
        logic       corr;
        logic [6:0] fixed;
        logic [6:0] one;
        s     = poly_mod(r);
        corr  = (s != 3'd0);
        pos   = 3'd0;
        fixed = r;
        if (corr) begin
            for (int i = 0; i < 7; i++) begin
                one = 7'd1 << i;
                if (poly_mod(one) == s) pos = 3'(i);
            end
            fixed = r ^ (7'd1 << pos);
        end
        return {fixed[6:3], s, corr, pos, 8'(errs)};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic b, input logic clr);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_bit   = b;
        bus.sync_clr = clr;
        if (clr) begin
            mdl_n = 0;
            mdl_r = 7'd0;
        end else if (v) begin
            mdl_r = {mdl_r[5:0], b};
            mdl_n++;
            if (mdl_n == 7) begin
                if (poly_mod(mdl_r) != 3'd0 && mdl_errs < 255) mdl_errs++;
                exp_q.push_back(decode_ref(mdl_r, mdl_errs));
                mdl_n = 0;
                mdl_r = 7'd0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic send_word(input logic [6:0] w);
        for (int i = 6; i >= 0; i--) drive(1'b1, w[i], 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  bus.data_out,  0);
        check({tag, "_oval"},  bus.out_valid, 0);
        check({tag, "_syn"},   bus.syndrome,  0);
        check({tag, "_corr"},  bus.corrected, 0);
        check({tag, "_pos"},   bus.err_pos,   0);
        check({tag, "_bcnt"},  bus.bit_cnt,   0);
        check({tag, "_ecnt"},  bus.err_count, 0);
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            pulse_cyc.push_back(cyc);
            check("expected_pulse", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                check("result",
                      {bus.data_out, bus.syndrome, bus.corrected, bus.err_pos, bus.err_count},
                      exp_q.pop_front());
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [6:0] w;
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        bus.sync_clr = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // clean codeword for m = 0001
        send_word(7'b0001011);
        idle(2);

        // single-error sweep over every position
        for (int i = 0; i < 7; i++) begin
            w = 7'b0001011 ^ (7'd1 << i);
            send_word(w);
            idle(1);
        end
        idle(1);
        check("sweep_errcnt", bus.err_count, 32'(mdl_errs));

        // every message back-to-back with in_valid held high
        pulse_cyc.delete();
        for (int m = 0; m < 16; m++) send_word(encode(4'(m)));
        idle(2);
        check("exh_pulses", 32'(pulse_cyc.size()), 16);
        for (int i = 1; i < pulse_cyc.size(); i++) begin
            check("exh_spacing", 32'(pulse_cyc[i] - pulse_cyc[i-1]), 7);
        end

        // double error is mis-corrected by the table
        send_word(7'b0001000);
        idle(2);

        // partial word aborted by sync_clr while in_valid is high
        for (int i = 0; i < 4; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        idle(1);
        check("pre_clr_bcnt", bus.bit_cnt, 32'(mdl_n));
        drive(1'b1, 1'($urandom_range(0, 1)), 1'b1);
        idle(1);
        check("clr_bcnt", bus.bit_cnt, 32'(mdl_n));

        // codeword 1000101 with random gaps
        w = 7'b1000101;
        for (int i = 6; i >= 0; i--) begin
            drive(1'b1, w[i], 1'b0);
            idle($urandom_range(0, 2));
        end
        idle(2);

        // async reset mid-codeword, between clock edges
        for (int i = 0; i < 3; i++) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        idle(1);
        check("pre_rst_bcnt", bus.bit_cnt, 32'(mdl_n));
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        mdl_n    = 0;
        mdl_r    = 7'd0;
        mdl_errs = 0;
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // saturation: random messages with a random single error
        for (int k = 0; k < 260; k++) begin
            w = encode(4'($urandom_range(0, 15))) ^ (7'd1 << $urandom_range(0, 6));
            send_word(w);
        end
        idle(2);
        check("sat_errcnt", bus.err_count, 32'(mdl_errs));

        for (int t = 0; t < 20 && exp_q.size() != 0; t++) idle(1);
        check("drain", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
